// File: rtl/divisor_arbiter.sv
// rtl/divisor_arbiter.sv - round-robin sharing of one Divisor_Algoritmico among NREQ requesters
// Divide-by-zero is answered locally; a watchdog aborts a divisor that never raises Done.
module divisor_arbiter #(
  parameter int tamanyo = 32,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                      CLK,
  input  logic                      RSTa,
  input  logic [NREQ-1:0]           Req,
  input  logic [NREQ*tamanyo-1:0]   Num_in,
  input  logic [NREQ*tamanyo-1:0]   Den_in,
  output logic [NREQ-1:0]           Ack,
  output logic [NREQ-1:0]           Valid,
  output logic [tamanyo-1:0]        Coc_out,
  output logic [tamanyo-1:0]        Res_out,
  output logic                      DivZero,
  output logic                      Err,
  output logic                      Busy,
  output logic                      Div_Start,
  output logic [tamanyo-1:0]        Div_Num,
  output logic [tamanyo-1:0]        Div_Den,
  input  logic [tamanyo-1:0]        Div_Coc,
  input  logic [tamanyo-1:0]        Div_Res,
  input  logic                      Div_Done
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

  state_t            state, state_next;
  logic [IW-1:0]     last, cur, win;
  logic              found;
  logic [TW-1:0]     timer;
  logic [tamanyo-1:0] num_w, den_w;
  logic [NREQ-1:0]   oh_win, oh_cur;
  logic              timeout_hit;

  // Scan starts just after the previous winner so every requester is reached within NREQ grants.
  always_comb begin
    int idx;
    win   = last;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last) + k) % NREQ;
      if (!found && Req[idx]) begin
        win   = IW'(idx);
        found = 1'b1;
      end
    end
  end

  assign num_w       = Num_in[int'(win)*tamanyo +: tamanyo];
  assign den_w       = Den_in[int'(win)*tamanyo +: tamanyo];
  assign oh_win      = NREQ'(1) << win;
  assign oh_cur      = NREQ'(1) << cur;
  assign timeout_hit = (timer == TW'(TIMEOUT - 1));

  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) state <= IDLE;
    else       state <= state_next;
  end

  // RESP lasts one cycle on the divisor path; the divide-by-zero path spends its
  // first RESP cycle forming the result and pulses Valid in the second.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (found) state_next = (den_w == '0) ? RESP : LAUNCH;
      LAUNCH:  state_next = WAIT;
      WAIT:    if (Div_Done || timeout_hit) state_next = RESP;
      RESP:    if (Valid != '0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) begin
      Ack       <= '0;
      Valid     <= '0;
      Div_Start <= 1'b0;
      DivZero   <= 1'b0;
      Err       <= 1'b0;
      Busy      <= 1'b0;
      Coc_out   <= '0;
      Res_out   <= '0;
      Div_Num   <= '0;
      Div_Den   <= '0;
      timer     <= '0;
      cur       <= '0;
      last      <= IW'(NREQ - 1);
    end else begin
      Ack       <= '0;
      Valid     <= '0;
      Div_Start <= 1'b0;
      Busy      <= (state_next != IDLE);
      case (state)
        IDLE: begin
          if (found) begin
            Div_Num   <= num_w;
            Div_Den   <= den_w;
            Ack       <= oh_win;
            cur       <= win;
            last      <= win;
            Div_Start <= (den_w != '0);
          end
        end
        LAUNCH: timer <= '0;
        WAIT: begin
          timer <= timer + TW'(1);
          if (Div_Done) begin
            Coc_out <= Div_Coc;
            Res_out <= Div_Res;
            DivZero <= 1'b0;
            Err     <= 1'b0;
            Valid   <= oh_cur;
          end else if (timeout_hit) begin
            Coc_out <= '0;
            Res_out <= '0;
            DivZero <= 1'b0;
            Err     <= 1'b1;
            Valid   <= oh_cur;
          end
        end
        RESP: begin
          if (Valid == '0) begin
            Coc_out <= '1;
            Res_out <= Div_Num;
            DivZero <= 1'b1;
            Err     <= 1'b0;
            Valid   <= oh_cur;
          end else begin
            DivZero <= 1'b0;
            Err     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/divisor_arbiter.md
Name: divisor_arbiter

Overview:
Shares one Divisor_Algoritmico instance among NREQ requesters with round-robin arbitration.
Latches the winner's operands and pulses the divisor's Start. Waits for Done and returns Coc/Res to the winner with a one-hot Valid pulse.
Handles divide-by-zero locally without starting the divisor, and recovers from a hung divisor with a watchdog.
Sits between the requester-side logic and the divisor datapath.

Parameters:
tamanyo, 32, operand/result width (matches divisor tamanyo)
NREQ, 4, number of requesters (2..8)
TIMEOUT, 64, max cycles from Div_Start to Div_Done before abort (>= tamanyo+4)

Ports:
CLK  in  1  clock, rising edge
RSTa  in  1  asynchronous active-low reset
Req  in  NREQ  per-requester request level
Num_in  in  NREQ*tamanyo  packed numerators, requester i at [i*tamanyo +: tamanyo]
Den_in  in  NREQ*tamanyo  packed denominators, same packing
Ack  out  NREQ  one-hot 1-cycle pulse: operands of requester i latched
Valid  out  NREQ  one-hot 1-cycle pulse: result for requester i on Coc_out/Res_out
Coc_out  out  tamanyo  quotient, held until next Valid
Res_out  out  tamanyo  remainder, held until next Valid
DivZero  out  1  qualifies Valid: Den was 0
Err  out  1  qualifies Valid: watchdog abort
Busy  out  1  high in every state except IDLE
Div_Start  out  1  divisor Start, 1-cycle pulse
Div_Num  out  tamanyo  divisor numerator, held from grant to RESP
Div_Den  out  tamanyo  divisor denominator, held from grant to RESP
Div_Coc  in  tamanyo  divisor quotient
Div_Res  in  tamanyo  divisor remainder
Div_Done  in  1  divisor completion

Behaviour:
- Reset (RSTa=0, async): state=IDLE. Ack, Valid, Div_Start, DivZero, Err, Busy=0. Coc_out, Res_out, Div_Num, Div_Den=0. Timer=0. Round-robin pointer last=NREQ-1, so requester 0 wins first. Reset mid-operation abandons the transaction; no Valid is ever issued for it.
- All outputs are registered.
- FSM states: IDLE, LAUNCH, WAIT, RESP.
- IDLE: Req is sampled only here. If Req!=0, winner w is the first set bit scanning last+1, last+2, ... mod NREQ. On that edge:
  - latch Num_in[w], Den_in[w] into Div_Num/Div_Den;
  - Ack[w]=1 for the next cycle;
  - store w; last<=w.
  - Next state: RESP with DivZero=1 if Den_in[w]==0, else LAUNCH.
- LAUNCH: Div_Start=1 for exactly this cycle; timer<=0; next state WAIT.
- WAIT: timer increments each cycle.
  - Div_Done=1: Coc_out<=Div_Coc, Res_out<=Div_Res, DivZero=0, Err=0; next state RESP.
  - Else, timer==TIMEOUT-1: Coc_out<=0, Res_out<=0, Err=1; next state RESP.
  - Done has priority if both occur on the same edge.
- Divide-by-zero path: Coc_out<=all ones, Res_out<=Div_Num (latched numerator), Err=0. The divisor is never started.
- RESP: Valid[w]=1 for exactly this cycle; next state IDLE. DivZero/Err are valid only while Valid!=0 and are cleared on leaving RESP.
- Div_Done outside WAIT is ignored.
- Requester contract: hold Req and operands stable until Ack. Deassert Req in the cycle after Ack, unless a new operation is wanted; a held Req re-enters arbitration.
- Req dropping before grant: no Ack.
- Latency, Den!=0: Req seen at IDLE edge k, then Ack in cycle k+1 with Div_Start in the same cycle. Valid arrives one cycle after the edge where Done=1 is sampled.
- Latency, Den==0: Ack cycle k+1, Valid cycle k+2.
- Fairness: with all Req held high, grants rotate 0,1,...,NREQ-1,0. No requester waits more than NREQ-1 transactions.
- Throughput: one transaction in flight. Minimum 1 IDLE cycle between consecutive grants.

Test Plan:
- Single request: Req=0001, Num0=100, Den0=7. Expect Ack=0001, then one Div_Start pulse, then Valid=0001 with Coc_out=14, Res_out=2, DivZero=0, Err=0.
- Round-robin: Req=1111 held, Num_i=50+i, Den=5. Expect grant order 0,1,2,3,0. Valid order matches, Coc=10,10,10,10. Res=0,1,2,3.
- Divide-by-zero: Req=0100, Num2=0xDEADBEEF, Den2=0. Expect Ack=0100 then Valid=0100 next cycle. Coc_out=0xFFFFFFFF, Res_out=0xDEADBEEF, DivZero=1, no Div_Start.
- Watchdog: stub holds Div_Done=0. Expect Valid with Err=1, Coc=Res=0 exactly TIMEOUT cycles after the WAIT entry; FSM then returns to IDLE and serves the next Req.
- Reset mid-WAIT: assert RSTa=0 asynchronously during WAIT. Expect all outputs 0 immediately, no Valid after release, and next grant to requester 0.
- Stray Done: pulse Div_Done in IDLE. Expect no Valid and no state change.
